instr_mem_loader: RTL and testbench

- Instruction-memory responder at the far end of the fetch path: takes the fetch unit's pc and returns the 32-bit instruction word in the same cycle.
- Owns a boot-load path. After reset it holds the core in reset.
- While the core is held, it accepts the program as a little-endian byte stream, assembles 32-bit words and writes them sequentially into the array. It then releases the core to RUN.

---
 rtl/instr_mem_loader_if.sv | 26 ++
 rtl/instr_mem_loader.sv | 123 ++++++++++++
 tb/tb_instr_mem_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Fetch and boot-load bus between the instruction memory loader and its neighbours.
// The responder side connects through the slave modport.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [31:0]     pc;
  logic [31:0]     instr;
  logic            fetch_fault;
  logic            fault_sticky;
  logic            load_valid;
  logic [7:0]      load_byte;
  logic            load_done;
  logic            load_ready;
  logic            core_hold;
  logic [ADDR_W:0] words_loaded;

  modport master (
    output pc, load_valid, load_byte, load_done,
    input  instr, fetch_fault, fault_sticky, load_ready, core_hold, words_loaded
  );

  modport slave (
    input  pc, load_valid, load_byte, load_done,
    output instr, fetch_fault, fault_sticky, load_ready, core_hold, words_loaded
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a boot-load path: holds the core in LOAD while a little-endian
// byte stream is packed into words, then serves zero-latency fetches in RUN.
module instr_mem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  instr_mem_loader_if.slave   bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  logic [31:0]      mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      asm_q, asm_d;
  logic [CNT_W-1:0] wr_addr_q, wr_addr_d;
  logic             core_hold_q, core_hold_d;
  logic             load_ready_q, load_ready_d;
  logic             fault_sticky_q, fault_sticky_d;

  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic             accept;
  logic [31:0]      merged;
  logic [1:0]       cnt_after;
  logic             pc_valid;
  logic             fetch_fault_c;

  // Fetch decode: word-aligned and inside the array
  assign pc_valid      = (bus.pc[1:0] == 2'b00) && (bus.pc[31:2] < 30'(DEPTH_WORDS));
  assign fetch_fault_c = (state_q == ST_RUN) && !pc_valid;

  assign bus.instr        = ((state_q == ST_RUN) && pc_valid) ? mem[bus.pc[ADDR_W+1:2]] : NOP_WORD;
  assign bus.fetch_fault  = fetch_fault_c;
  assign bus.fault_sticky = fault_sticky_q;
  assign bus.load_ready   = load_ready_q;
  assign bus.core_hold    = core_hold_q;
  assign bus.words_loaded = wr_addr_q;

  // Next-state: byte accept first, then 4th-byte write or done-flush, then transition
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    wr_addr_d      = wr_addr_q;
    mem_we         = 1'b0;
    mem_wdata      = 32'h0;
    accept         = 1'b0;
    cnt_after      = byte_cnt_q;
    merged         = asm_q | (32'(bus.load_byte) << {byte_cnt_q, 3'b000});
    fault_sticky_d = fault_sticky_q | fetch_fault_c;

    case (state_q)
      ST_LOAD: begin
        accept    = bus.load_valid && load_ready_q;
        cnt_after = byte_cnt_q + 2'(accept);
        if (accept && (byte_cnt_q == 2'd3)) begin
          mem_we     = 1'b1;
          mem_wdata  = merged;
          wr_addr_d  = wr_addr_q + CNT_W'(1);
          byte_cnt_d = 2'd0;
          asm_d      = 32'h0;
        end else if (bus.load_done && (cnt_after != 2'd0)) begin
          mem_we     = 1'b1;
          mem_wdata  = accept ? merged : asm_q;
          wr_addr_d  = wr_addr_q + CNT_W'(1);
          byte_cnt_d = 2'd0;
          asm_d      = 32'h0;
        end else begin
          byte_cnt_d = cnt_after;
          asm_d      = accept ? merged : asm_q;
        end
        if (bus.load_done || (wr_addr_q == DEPTH_C)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    core_hold_d  = (state_d == ST_LOAD);
    load_ready_d = (state_d == ST_LOAD) && (wr_addr_d < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      byte_cnt_q     <= 2'd0;
      asm_q          <= 32'h0;
      wr_addr_q      <= '0;
      core_hold_q    <= 1'b1;
      load_ready_q   <= 1'b1;
      fault_sticky_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      wr_addr_q      <= wr_addr_d;
      core_hold_q    <= core_hold_d;
      load_ready_q   <= load_ready_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  // Array keeps its contents across reset; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[wr_addr_q[ADDR_W-1:0]] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed, table-driven bench for instr_mem_loader on a 4-word array.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  b;
    logic        d;
    logic [31:0] pc;
    logic [31:0] e_instr;
    logic        e_fault;
    logic        e_sticky;
    logic        e_hold;
    logic        e_ready;
    logic [2:0]  e_words;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  instr_mem_loader_if #(.ADDR_W(AW)) bus ();

  instr_mem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic v, input logic [7:0] b, input logic d,
                     input logic [31:0] pc, input logic [31:0] ei, input logic ef,
                     input logic es, input logic eh, input logic er, input logic [2:0] ew);
    vec_t t;
    t.rst = rst; t.v = v; t.b = b; t.d = d; t.pc = pc;
    t.e_instr = ei; t.e_fault = ef; t.e_sticky = es; t.e_hold = eh; t.e_ready = er;
    t.e_words = ew;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] b, input logic d,
                       input logic [31:0] pc);
    @(negedge clk);
    reset          = r;
    bus.load_valid = v;
    bus.load_byte  = b;
    bus.load_done  = d;
    bus.pc         = pc;
    #1;
  endtask

  initial begin
    int waited;
    reset = 1'b1; bus.load_valid = 1'b0; bus.load_byte = 8'h0; bus.load_done = 1'b0;
    bus.pc = 32'h0;

    // Basic load: two words, then done; outputs are those seen before each row's edge
    add(0,1,8'h13,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h05,0,4,   NOP,0,0,1,1,0);
    add(0,1,8'h50,0,8,   NOP,0,0,1,1,0);
    add(0,1,8'h00,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h93,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h05,0,2,   NOP,0,0,1,1,1);
    add(0,1,8'h10,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,1,0,   NOP,0,0,1,1,2);
    add(0,0,8'h00,0,4,   32'h0010_0593,0,0,0,0,2);
    add(0,0,8'h00,0,0,   32'h0050_0513,0,0,0,0,2);
    add(0,1,8'hFF,1,0,   32'h0050_0513,0,0,0,0,2);
    add(0,0,8'h00,0,4,   32'h0010_0593,0,0,0,0,2);
    // Invalid fetches in RUN
    add(0,0,8'h00,0,2,   NOP,1,0,0,0,2);
    add(0,0,8'h00,0,0,   32'h0050_0513,0,1,0,0,2);
    add(0,0,8'h00,0,16,  NOP,1,1,0,0,2);
    add(0,0,8'h00,0,32'h8000_0000, NOP,1,1,0,0,2);
    add(0,0,8'h00,0,0,   32'h0050_0513,0,1,0,0,2);
    // Reset from RUN, then partial flush with the 3rd byte and done together
    add(1,0,8'h00,0,0,   32'h0050_0513,0,1,0,0,2);
    add(0,1,8'hAA,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'hBB,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'hCC,1,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,0,0,   32'h00CC_BBAA,0,0,0,0,1);
    add(0,0,8'h00,0,4,   32'h0010_0593,0,0,0,0,1);
    // Reset mid-load after 6 bytes
    add(1,0,8'h00,0,0,   32'h00CC_BBAA,0,0,0,0,1);
    add(0,1,8'h11,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h22,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h33,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h44,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'h55,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h66,0,0,   NOP,0,0,1,1,1);
    add(1,0,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'hDE,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'hAD,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'hBE,0,0,   NOP,0,0,1,1,0);
    add(0,1,8'hEF,0,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,1,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,0,0,   32'hEFBE_ADDE,0,0,0,0,1);
    add(0,0,8'h00,0,4,   32'h0010_0593,0,0,0,0,1);
    // Gapped stream, NOP for every pc while loading
    add(1,0,8'h00,0,0,   32'hEFBE_ADDE,0,0,0,0,1);
    add(0,1,8'h13,0,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,0,4,   NOP,0,0,1,1,0);
    add(0,1,8'h05,0,8,   NOP,0,0,1,1,0);
    add(0,0,8'hAB,0,2,   NOP,0,0,1,1,0);
    add(0,1,8'h50,0,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,0,12,  NOP,0,0,1,1,0);
    add(0,1,8'h00,0,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h93,0,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h05,0,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h10,0,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,1,8'h00,0,0,   NOP,0,0,1,1,1);
    add(0,0,8'h00,1,0,   NOP,0,0,1,1,2);
    add(0,0,8'h00,0,0,   32'h0050_0513,0,0,0,0,2);
    add(0,0,8'h00,0,4,   32'h0010_0593,0,0,0,0,2);
    // Full array: 16 bytes fill it, extra bytes are refused
    add(1,0,8'h00,0,0,   32'h0050_0513,0,0,0,0,2);
    for (int i = 0; i < 16; i++)
      add(0,1,8'(i+1),0,32'(4*(i%4)), NOP,0,0,1,1,3'(i/4));
    add(0,1,8'hAA,0,0,   NOP,0,0,1,0,4);
    add(0,1,8'hBB,0,0,   32'h0403_0201,0,0,0,0,4);
    add(0,1,8'hCC,0,4,   32'h0807_0605,0,0,0,0,4);
    add(0,1,8'hDD,0,8,   32'h0C0B_0A09,0,0,0,0,4);
    add(0,0,8'h00,0,12,  32'h100F_0E0D,0,0,0,0,4);
    add(0,0,8'h00,0,16,  NOP,1,0,0,0,4);
    add(0,0,8'h00,0,12,  32'h100F_0E0D,0,1,0,0,4);
    // Done with no bytes: RUN with zero words, array contents kept
    add(1,0,8'h00,0,0,   32'h0403_0201,0,1,0,0,4);
    add(0,0,8'h00,1,0,   NOP,0,0,1,1,0);
    add(0,0,8'h00,0,0,   32'h0403_0201,0,0,0,0,0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].v, vecs[i].b, vecs[i].d, vecs[i].pc);
      chk("instr",        i, bus.instr,               vecs[i].e_instr);
      chk("fetch_fault",  i, 32'(bus.fetch_fault),    32'(vecs[i].e_fault));
      chk("fault_sticky", i, 32'(bus.fault_sticky),   32'(vecs[i].e_sticky));
      chk("core_hold",    i, 32'(bus.core_hold),      32'(vecs[i].e_hold));
      chk("load_ready",   i, 32'(bus.load_ready),     32'(vecs[i].e_ready));
      chk("words_loaded", i, 32'(bus.words_loaded),   32'(vecs[i].e_words));
    end

    // 4th byte arriving together with done: one write, no extra flush
    cycle(1,0,8'h00,0,0);
    cycle(0,1,8'h77,0,0);
    chk("seq_hold_after_reset", 0, 32'(bus.core_hold), 32'd1);
    chk("seq_words_after_reset", 0, 32'(bus.words_loaded), 32'd0);
    cycle(0,1,8'h66,0,0);
    cycle(0,1,8'h55,0,0);
    cycle(0,1,8'h44,1,0);
    chk("seq_ready_last_byte", 0, 32'(bus.load_ready), 32'd1);
    waited = 0;
    while (bus.core_hold !== 1'b0 && waited < 8) begin
      cycle(0,0,8'h00,0,0);
      waited++;
    end
    chk("seq_hold_fall_latency", 0, 32'(waited), 32'd1);
    chk("seq_words", 0, 32'(bus.words_loaded), 32'd1);
    chk("seq_mem0", 0, bus.instr, 32'h4455_6677);
    cycle(0,0,8'h00,0,4);
    chk("seq_mem1_kept", 0, bus.instr, 32'h0807_0605);
    chk("seq_fault_clear", 0, 32'(bus.fetch_fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
